// File: rtl/seg_accum_multi.sv
// Multi-channel segment accumulator: each channel loads a base on a start beat,
// adds signed data beats until an end beat, then strobes a registered result.
module seg_accum_multi #(
  parameter int NUM_CH     = 2,
  parameter int D_WIDTH    = 2,
  parameter int BASE_WIDTH = 18,
  parameter int ACC_WIDTH  = 19,
  parameter int LEN_WIDTH  = 8,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [BASE_WIDTH-1:0]          base,
  input  logic [NUM_CH-1:0]              in_valid,
  input  logic [NUM_CH-1:0]              in_start,
  input  logic [NUM_CH-1:0]              in_end,
  input  logic [NUM_CH*D_WIDTH-1:0]      in_data,
  output logic [NUM_CH-1:0]              busy,
  output logic [NUM_CH-1:0]              out_valid,
  output logic [NUM_CH*ACC_WIDTH-1:0]    out_acc,
  output logic [NUM_CH*LEN_WIDTH-1:0]    out_len,
  output logic [NUM_CH-1:0]              out_ovf,
  output logic [NUM_CH-1:0]              out_abort
);

  typedef enum logic {S_IDLE = 1'b0, S_ACCUM = 1'b1} state_t;

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic                   ovf_q, ovf_d;
    logic                   oval_q, oval_d;
    logic                   oabt_q, oabt_d;
    logic [ACC_WIDTH-1:0]   oacc_q, oacc_d;
    logic [LEN_WIDTH-1:0]   olen_q, olen_d;
    logic                   oovf_q, oovf_d;

    logic [D_WIDTH-1:0]     data_c;
    logic [ACC_WIDTH:0]     addend, data_x, sum;
    logic [ACC_WIDTH-1:0]   sum_fit;
    logic                   beat_ovf;

    assign data_c = in_data[c*D_WIDTH +: D_WIDTH];

    // One extra bit of headroom; overflow shows as disagreement of the top two bits.
    always_comb begin
      data_x = {{(ACC_WIDTH+1-D_WIDTH){data_c[D_WIDTH-1]}}, data_c};
      if (in_start[c])
        addend = {{(ACC_WIDTH+1-BASE_WIDTH){1'b0}}, base};
      else
        addend = {acc_q[ACC_WIDTH-1], acc_q};
      sum      = addend + data_x;
      beat_ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
      if (beat_ovf && SATURATE)
        sum_fit = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
      else
        sum_fit = sum[ACC_WIDTH-1:0];
    end

    always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      len_d   = len_q;
      ovf_d   = ovf_q;
      oval_d  = 1'b0;
      oabt_d  = 1'b0;
      oacc_d  = oacc_q;
      olen_d  = olen_q;
      oovf_d  = oovf_q;
      if (in_valid[c]) begin
        if (in_start[c]) begin
          oabt_d  = (state_q == S_ACCUM);
          acc_d   = sum_fit;
          len_d   = LEN_ONE;
          ovf_d   = beat_ovf;
          state_d = in_end[c] ? S_IDLE : S_ACCUM;
        end else if (state_q == S_ACCUM) begin
          acc_d   = sum_fit;
          len_d   = (&len_q) ? len_q : len_q + 1'b1;
          ovf_d   = ovf_q | beat_ovf;
          if (in_end[c]) state_d = S_IDLE;
        end
        if (in_end[c] && (in_start[c] || state_q == S_ACCUM)) begin
          oval_d = 1'b1;
          oacc_d = acc_d;
          olen_d = len_d;
          oovf_d = ovf_d;
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= S_IDLE;
        acc_q   <= '0;
        len_q   <= '0;
        ovf_q   <= 1'b0;
        oval_q  <= 1'b0;
        oabt_q  <= 1'b0;
        oacc_q  <= '0;
        olen_q  <= '0;
        oovf_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        acc_q   <= acc_d;
        len_q   <= len_d;
        ovf_q   <= ovf_d;
        oval_q  <= oval_d;
        oabt_q  <= oabt_d;
        oacc_q  <= oacc_d;
        olen_q  <= olen_d;
        oovf_q  <= oovf_d;
      end
    end

    assign busy[c]                             = (state_q == S_ACCUM);
    assign out_valid[c]                        = oval_q;
    assign out_abort[c]                        = oabt_q;
    assign out_ovf[c]                          = oovf_q;
    assign out_acc[c*ACC_WIDTH +: ACC_WIDTH]   = oacc_q;
    assign out_len[c*LEN_WIDTH +: LEN_WIDTH]   = olen_q;
  end

endmodule

// File: tb/tb_seg_accum_multi.sv
// Bench for seg_accum_multi: saturating and wrapping instances share stimulus and
// are compared every cycle against an integer-arithmetic segment model.
module tb_seg_accum_multi;
  localparam int NC = 2;
  localparam int DW = 2;
  localparam int BW = 18;
  localparam int AW = 19;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [BW-1:0]    base = '0;
  logic [NC-1:0]    in_valid = '0, in_start = '0, in_end = '0;
  logic [NC*DW-1:0] in_data = '0;

  logic [NC-1:0]    busy_s, oval_s, oovf_s, oabt_s;
  logic [NC*AW-1:0] oacc_s;
  logic [NC*LW-1:0] olen_s;
  logic [NC-1:0]    busy_w, oval_w, oovf_w, oabt_w;
  logic [NC*AW-1:0] oacc_w;
  logic [NC*LW-1:0] olen_w;

  always #5 clk = ~clk;

  seg_accum_multi #(.NUM_CH(NC), .D_WIDTH(DW), .BASE_WIDTH(BW), .ACC_WIDTH(AW),
                    .LEN_WIDTH(LW), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .base(base), .in_valid(in_valid), .in_start(in_start),
    .in_end(in_end), .in_data(in_data), .busy(busy_s), .out_valid(oval_s),
    .out_acc(oacc_s), .out_len(olen_s), .out_ovf(oovf_s), .out_abort(oabt_s));

  seg_accum_multi #(.NUM_CH(NC), .D_WIDTH(DW), .BASE_WIDTH(BW), .ACC_WIDTH(AW),
                    .LEN_WIDTH(LW), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .reset(reset), .base(base), .in_valid(in_valid), .in_start(in_start),
    .in_end(in_end), .in_data(in_data), .busy(busy_w), .out_valid(oval_w),
    .out_acc(oacc_w), .out_len(olen_w), .out_ovf(oovf_w), .out_abort(oabt_w));

  int checks = 0;
  int errors = 0;

  // Model state, index [m][c]; m=0 saturating instance, m=1 wrapping instance.
  bit     m_open [2][NC];
  longint m_acc  [2][NC];
  int     m_len  [2][NC];
  bit     m_ovf  [2][NC];
  bit     e_valid[2][NC];
  bit     e_abort[2][NC];
  bit     e_ovf  [2][NC];
  longint e_acc  [2][NC];
  int     e_len  [2][NC];

  localparam longint HI = (longint'(1) << (AW-1)) - 1;
  localparam longint LO = -(longint'(1) << (AW-1));

  task automatic check(string tag, int m, int c, longint obs, longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d ch%0d observed=%0d expected=%0d", tag, m, c, obs, exp);
    end
  endtask

  function automatic longint acc_of(int m, int c);
    logic [AW-1:0] v;
    v = (m == 0) ? oacc_s[c*AW +: AW] : oacc_w[c*AW +: AW];
    return longint'($signed(v));
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < NC; c++) begin
        m_open[m][c] = 0; m_acc[m][c] = 0; m_len[m][c] = 0; m_ovf[m][c] = 0;
        e_valid[m][c] = 0; e_abort[m][c] = 0; e_ovf[m][c] = 0;
        e_acc[m][c] = 0; e_len[m][c] = 0;
      end
  endtask

  // Add with range check; saturate or wrap into the signed accumulator range.
  task automatic fit(int m, input longint s, output longint r, output bit ov);
    longint w;
    ov = (s > HI) || (s < LO);
    if (!ov) r = s;
    else if (m == 0) r = (s > HI) ? HI : LO;
    else begin
      w = s & ((longint'(1) << AW) - 1);
      if (w > HI) w = w - (longint'(1) << AW);
      r = w;
    end
  endtask

  task automatic model_beat(int m, int c);
    logic [DW-1:0] dv;
    longint d, r;
    bit ov;
    e_valid[m][c] = 0;
    e_abort[m][c] = 0;
    if (!in_valid[c]) return;
    dv = in_data[c*DW +: DW];
    d  = longint'($signed(dv));
    if (in_start[c]) begin
      e_abort[m][c] = m_open[m][c];
      fit(m, longint'(base) + d, r, ov);
      m_acc[m][c] = r; m_len[m][c] = 1; m_ovf[m][c] = ov;
      m_open[m][c] = !in_end[c];
    end else if (m_open[m][c]) begin
      fit(m, m_acc[m][c] + d, r, ov);
      m_acc[m][c] = r;
      m_len[m][c] = (m_len[m][c] >= (1 << LW) - 1) ? (1 << LW) - 1 : m_len[m][c] + 1;
      m_ovf[m][c] = m_ovf[m][c] | ov;
      if (in_end[c]) m_open[m][c] = 0;
    end else return;
    if (in_end[c]) begin
      e_valid[m][c] = 1;
      e_acc[m][c] = m_acc[m][c];
      e_len[m][c] = m_len[m][c];
      e_ovf[m][c] = m_ovf[m][c];
    end
  endtask

  task automatic compare_all();
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < NC; c++) begin
        logic [LW-1:0] l;
        logic b, v, o, a;
        if (m == 0) begin
          l = olen_s[c*LW +: LW]; b = busy_s[c]; v = oval_s[c]; o = oovf_s[c]; a = oabt_s[c];
        end else begin
          l = olen_w[c*LW +: LW]; b = busy_w[c]; v = oval_w[c]; o = oovf_w[c]; a = oabt_w[c];
        end
        check("busy",  m, c, longint'(b), longint'(m_open[m][c]));
        check("valid", m, c, longint'(v), longint'(e_valid[m][c]));
        check("abort", m, c, longint'(a), longint'(e_abort[m][c]));
        check("acc",   m, c, acc_of(m, c), e_acc[m][c]);
        check("len",   m, c, longint'(l), longint'(e_len[m][c]));
        check("ovf",   m, c, longint'(o), longint'(e_ovf[m][c]));
      end
  endtask

  task automatic step();
    if (reset) model_reset();
    else
      for (int m = 0; m < 2; m++)
        for (int c = 0; c < NC; c++) model_beat(m, c);
    @(posedge clk);
    #1;
    compare_all();
    in_valid = '0; in_start = '0; in_end = '0; in_data = '0;
  endtask

  task automatic set_beat(int c, bit s, bit e, int d);
    logic [DW-1:0] dv;
    dv = d[DW-1:0];
    in_valid[c] = 1'b1;
    in_start[c] = s;
    in_end[c]   = e;
    in_data[c*DW +: DW] = dv;
  endtask

  initial begin
    model_reset();
    step();
    step();
    #1 reset = 1'b0;
    step();

    // Three-beat segment on ch0
    base = 18'd5;
    set_beat(0, 1, 0, 1);  step();
    set_beat(0, 0, 0, -2); step();
    set_beat(0, 0, 1, 1);  step();
    check("t1_acc", 0, 0, acc_of(0, 0), 5);
    check("t1_len", 0, 0, longint'(olen_s[LW-1:0]), 3);
    check("t1_valid", 0, 0, longint'(oval_s), 1);
    step();

    // Overflow at top of range: clamp vs wrap
    base = 18'h3FFFF;
    set_beat(0, 1, 0, 1); step();
    set_beat(0, 0, 1, 1); step();
    check("t2_sat_acc", 0, 0, acc_of(0, 0), 262143);
    check("t2_wrap_acc", 1, 0, acc_of(1, 0), -262143);
    check("t2_sat_ovf", 0, 0, longint'(oovf_s[0]), 1);
    check("t2_wrap_ovf", 1, 0, longint'(oovf_w[0]), 1);
    step();

    // Abort with single-beat restart on ch1
    base = 18'd7;
    set_beat(1, 1, 0, 1); step();
    base = 18'd2;
    set_beat(1, 1, 1, -1); step();
    check("t3_abort", 0, 1, longint'(oabt_s[1]), 1);
    check("t3_valid", 0, 1, longint'(oval_s[1]), 1);
    check("t3_acc", 0, 1, acc_of(0, 1), 1);
    check("t3_len", 0, 1, longint'(olen_s[2*LW-1:LW]), 1);
    step();

    // Both channels in lockstep
    base = 18'd0;
    for (int i = 0; i < 4; i++) begin
      set_beat(0, i == 0, i == 3, 1);
      set_beat(1, i == 0, i == 3, -1);
      step();
    end
    check("t4_valid", 0, 0, longint'(oval_s), 3);
    check("t4_acc0", 0, 0, acc_of(0, 0), 4);
    check("t4_acc1", 0, 1, acc_of(0, 1), -4);
    step();

    // Async reset mid-segment
    base = 18'd9;
    set_beat(0, 1, 0, 1); step();
    set_beat(0, 0, 0, 1); step();
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("t5_busy", 0, 0, longint'(busy_s), 0);
    step();
    #1 reset = 1'b0;
    set_beat(0, 0, 1, 1); step();
    check("t5_novalid", 0, 0, longint'(oval_s), 0);
    step();

    // Non-start beats while idle are ignored
    base = 18'd3;
    set_beat(0, 1, 1, 1); step();
    for (int i = 0; i < 3; i++) begin set_beat(0, 0, 0, 1); step(); end
    check("t6_busy", 0, 0, longint'(busy_s[0]), 0);
    check("t6_acc_held", 0, 0, acc_of(0, 0), 4);

    // Long segment: beat count saturates
    base = 18'd100;
    set_beat(0, 1, 0, 0); step();
    for (int i = 0; i < 299; i++) begin set_beat(0, 0, i == 298, 0); step(); end
    check("len_sat", 0, 0, longint'(olen_s[LW-1:0]), 255);
    step();

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 1) == 1) base = BW'(18'h3FFF0 + $urandom_range(0, 15));
      else base = BW'($urandom);
      for (int c = 0; c < NC; c++)
        if ($urandom_range(0, 3) != 0)
          set_beat(c, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                   int'($urandom_range(0, 3)));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
